oled_spi_sequencer: RTL

Sequences byte transfers into the SPI master that drives the SSD1306 panel. Runs the panel hardware-reset/power-up sequence, buffers command/data bytes in an internal FIFO, and drives the D/C line so it matches each byte. Generates the SPI master's `data_in`/`wr` handshake with guaranteed setup and hold timing. Sits between the display frame logic and the SPI master, all on one clock.

---
 rtl/oled_spi_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/oled_spi_sequencer.sv
// SSD1306 SPI byte sequencer: panel reset/power-up, byte FIFO, D/C tracking
// and a setup/strobe/hold write handshake into the SPI master.
module oled_spi_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned RESET_CYCLES   = 1000,
  parameter int unsigned POWERUP_CYCLES = 10000,
  parameter int unsigned WR_CYCLES      = 2,
  parameter logic [2:0]  PRESCALE       = 3'd2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_reinit,
  input  logic                          i_in_valid,
  input  logic                          i_in_dc,
  input  logic [7:0]                    i_in_byte,
  output logic                          o_in_ready,
  output logic [7:0]                    o_spi_data,
  output logic                          o_spi_wr,
  input  logic                          i_spi_buffempty,
  input  logic                          i_spi_ss,
  input  logic                          i_spi_senderr,
  output logic                          o_spi_res_senderr,
  output logic [2:0]                    o_spi_prescaller,
  output logic [1:0]                    o_spi_mode,
  output logic                          o_spi_lsbfirst,
  output logic                          o_oled_res_n,
  output logic                          o_oled_dc,
  output logic                          o_ready,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_err
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned TMAX0 = (RESET_CYCLES > POWERUP_CYCLES) ? RESET_CYCLES : POWERUP_CYCLES;
  localparam int unsigned TMAX  = (TMAX0 > WR_CYCLES) ? TMAX0 : WR_CYCLES;
  localparam int unsigned TW    = $clog2(TMAX + 2);

  typedef enum logic [2:0] {
    StRstLow, StRstWait, StIdle, StSetup, StStrobe, StHold
  } state_e;

  state_e          r_state, w_state_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [7:0]      r_spi_data, w_spi_data_nxt;
  logic            r_oled_dc, w_oled_dc_nxt;
  logic            w_pop;

  logic [8:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [LW-1:0]   r_count;
  logic            w_full, w_empty, w_push;
  logic [8:0]      w_head;

  logic            r_err;
  logic [1:0]      r_res_cnt;

  assign w_full  = (r_count == LW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rptr];
  assign w_push  = i_in_valid & o_in_ready;

  // FIFO pointers and occupancy; reinit flushes without touching storage
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_reinit) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + LW'(1);
      else if (!w_push && w_pop) r_count <= r_count - LW'(1);
    end
  end

  // FIFO storage: {dc, byte}
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= {i_in_dc, i_in_byte};
  end

  // Sequencer state, timer and the registered SPI data / D/C lines
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StRstLow;
      r_timer    <= '0;
      r_spi_data <= '0;
      r_oled_dc  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_spi_data <= w_spi_data_nxt;
      r_oled_dc  <= w_oled_dc_nxt;
    end
  end

  // Next-state logic; D/C may only switch while no frame is active (ss high)
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_spi_data_nxt = r_spi_data;
    w_oled_dc_nxt  = r_oled_dc;
    w_pop          = 1'b0;
    if (i_reinit) begin
      w_state_nxt = StRstLow;
      w_timer_nxt = '0;
    end else begin
      unique case (r_state)
        StRstLow: begin
          if (r_timer == TW'(RESET_CYCLES - 1)) begin
            w_state_nxt = StRstWait;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        StRstWait: begin
          if (r_timer == TW'(POWERUP_CYCLES - 1)) begin
            w_state_nxt = StIdle;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        StIdle: begin
          if (!w_empty && i_spi_buffempty && !((w_head[8] != r_oled_dc) && !i_spi_ss)) begin
            w_spi_data_nxt = w_head[7:0];
            w_oled_dc_nxt  = w_head[8];
            w_pop          = 1'b1;
            w_state_nxt    = StSetup;
          end
        end
        StSetup: begin
          w_state_nxt = StStrobe;
          w_timer_nxt = '0;
        end
        StStrobe: begin
          if (r_timer == TW'(WR_CYCLES - 1)) begin
            w_state_nxt = StHold;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        StHold: begin
          if (r_timer == TW'(1)) begin
            w_state_nxt = StIdle;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        default: begin
          w_state_nxt = StRstLow;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  // Sticky error flag and a two-clock res_senderr pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err     <= 1'b0;
      r_res_cnt <= 2'd0;
    end else begin
      if (i_spi_senderr)          r_res_cnt <= 2'd2;
      else if (r_res_cnt != 2'd0) r_res_cnt <= r_res_cnt - 2'd1;
      if (i_reinit)           r_err <= 1'b0;
      else if (i_spi_senderr) r_err <= 1'b1;
    end
  end

  assign o_ready           = (r_state != StRstLow) && (r_state != StRstWait);
  assign o_in_ready        = !w_full && o_ready;
  assign o_spi_wr          = (r_state == StStrobe);
  assign o_spi_data        = r_spi_data;
  assign o_oled_dc         = r_oled_dc;
  assign o_oled_res_n      = (r_state != StRstLow);
  assign o_busy            = !w_empty || (r_state != StIdle) || !i_spi_ss;
  assign o_fifo_level      = r_count;
  assign o_err             = r_err;
  assign o_spi_res_senderr = (r_res_cnt != 2'd0);
  assign o_spi_prescaller  = PRESCALE;
  assign o_spi_mode        = 2'b00;
  assign o_spi_lsbfirst    = 1'b0;

endmodule
